tr_tracker: RTL and testbench

TR_TRACKER -- requirements
Module: tr_tracker

---
 rtl/tr_pkg.sv | 15 +
 rtl/tr_step_pulse.sv | 41 ++++
 rtl/tr_tracker.sv | 104 ++++++++++
 tb/tb_tr_tracker.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tr_pkg.sv
// Shared defaults and types for the tracking-mode stepper controller.
package tr_pkg;

  localparam int XW_DEFAULT    = 12;
  localparam int NW_DEFAULT    = 17;
  localparam int N_MAX_DEFAULT = 100000;
  localparam int N_MIN_DEFAULT = 1000;
  localparam int SLOPE_DEFAULT = 64;

  typedef enum logic {
    DIR_BELOW = 1'b0,
    DIR_ABOVE = 1'b1
  } dir_t;

endpackage

// File: rtl/tr_step_pulse.sv
// Step pulse generator: counts timebase ticks and emits a one-clock step every n_period ticks.
module tr_step_pulse
  import tr_pkg::*;
#(
  parameter int NW = NW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          data_valid_trig,
  input  logic          enable,
  input  logic [NW-1:0] n_period,
  output logic          drv_step
);

  logic [NW-1:0] tick_cnt;
  logic [NW-1:0] last_tick;

  // Periods below 2 are clamped to 2 so a step is never held high continuously.
  always_comb begin
    last_tick = (n_period < NW'(2)) ? NW'(1) : n_period - NW'(1);
  end

  // ">=" rather than "==" so a shortened period fires on the next tick instead of wrapping the counter.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      tick_cnt <= '0;
      drv_step <= 1'b0;
    end else begin
      drv_step <= 1'b0;
      if (data_valid_trig) begin
        if (tick_cnt >= last_tick) begin
          tick_cnt <= '0;
          drv_step <= 1'b1;
        end else begin
          tick_cnt <= tick_cnt + NW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/tr_tracker.sv
// Tracking controller: hysteretic motor enable, direction and error-proportional step period
// derived from ADC samples, driving the step pulse generator.
module tr_tracker
  import tr_pkg::*;
#(
  parameter int XW    = XW_DEFAULT,
  parameter int NW    = NW_DEFAULT,
  parameter int N_MAX = N_MAX_DEFAULT,
  parameter int N_MIN = N_MIN_DEFAULT,
  parameter int SLOPE = SLOPE_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          data_valid,
  input  logic          data_valid_trig,
  input  logic          tr_mode_enable,
  input  logic [XW-1:0] x,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] dx1,
  input  logic [XW-1:0] dx2,
  output logic          drv_step,
  output logic          drv_dir,
  output logic          drv_enable_sm,
  output logic [NW-1:0] n_period
);

  localparam int PW = XW + NW + 1;

  logic signed [XW:0] err;
  logic [XW:0]        abs_err;
  logic [XW:0]        excess;
  logic               inside_dx1;
  logic               outside_dx2;
  logic               en_upd;
  logic               en_next;
  logic               dir_upd;
  logic               pulse_enable;
  logic [PW-1:0]      slope_term;
  logic [NW-1:0]      period_upd;

  // The extra sign bit keeps |e| exact even at full-scale error.
  always_comb begin
    err         = $signed({1'b0, x}) - $signed({1'b0, x0});
    abs_err     = err[XW] ? $unsigned(-err) : $unsigned(err);
    inside_dx1  = abs_err <= {1'b0, dx1};
    outside_dx2 = abs_err > {1'b0, dx2};
    en_upd      = (drv_enable_sm | outside_dx2) & ~inside_dx1;
    excess      = abs_err - {1'b0, dx1};
    slope_term  = PW'(SLOPE) * PW'(excess);

    if (!en_upd) begin
      period_upd = NW'(N_MAX);
    end else if (slope_term >= PW'(N_MAX - N_MIN)) begin
      period_upd = NW'(N_MIN);
    end else begin
      period_upd = NW'(PW'(N_MAX) - slope_term);
    end

    if (err[XW]) begin
      dir_upd = DIR_BELOW;
    end else if (err != '0) begin
      dir_upd = DIR_ABOVE;
    end else begin
      dir_upd = drv_dir;
    end

    en_next = drv_enable_sm;
    if (!tr_mode_enable) begin
      en_next = 1'b0;
    end else if (data_valid) begin
      en_next = en_upd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drv_enable_sm <= 1'b0;
      drv_dir       <= DIR_BELOW;
      n_period      <= NW'(N_MAX);
    end else if (!tr_mode_enable) begin
      drv_enable_sm <= 1'b0;
      n_period      <= NW'(N_MAX);
    end else if (data_valid) begin
      drv_enable_sm <= en_upd;
      drv_dir       <= dir_upd;
      n_period      <= period_upd;
    end
  end

  // Gating with the next enable too stops a step landing on the same clock the motor is disabled.
  assign pulse_enable = drv_enable_sm & en_next;

  tr_step_pulse #(
    .NW(NW)
  ) u_step (
    .clk            (clk),
    .rst            (rst),
    .data_valid_trig(data_valid_trig),
    .enable         (pulse_enable),
    .n_period       (n_period),
    .drv_step       (drv_step)
  );

endmodule

// File: tb/tb_tr_tracker.sv
// Testbench for tr_tracker: table of control-path vectors checked through a scoreboard,
// plus hand-written step-timing sequences on the top and on a standalone pulse generator.
module tb_tr_tracker;
  import tr_pkg::*;

  localparam int XW = 12;
  localparam int NW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          data_valid = 1'b0;
  logic          data_valid_trig = 1'b0;
  logic          tr_mode_enable = 1'b0;
  logic [XW-1:0] x = '0;
  logic [XW-1:0] x0 = 12'd10;
  logic [XW-1:0] dx1 = 12'd45;
  logic [XW-1:0] dx2 = 12'd60;
  logic          drv_step;
  logic          drv_dir;
  logic          drv_enable_sm;
  logic [NW-1:0] n_period;

  logic          p_rst = 1'b1;
  logic          p_trig = 1'b0;
  logic          p_en = 1'b0;
  logic [NW-1:0] p_n = '0;
  logic          p_step;

  always #5 clk = ~clk;

  tr_tracker dut (
    .clk            (clk),
    .rst            (rst),
    .data_valid     (data_valid),
    .data_valid_trig(data_valid_trig),
    .tr_mode_enable (tr_mode_enable),
    .x              (x),
    .x0             (x0),
    .dx1            (dx1),
    .dx2            (dx2),
    .drv_step       (drv_step),
    .drv_dir        (drv_dir),
    .drv_enable_sm  (drv_enable_sm),
    .n_period       (n_period)
  );

  tr_step_pulse #(
    .NW(NW)
  ) u_pulse (
    .clk            (clk),
    .rst            (p_rst),
    .data_valid_trig(p_trig),
    .enable         (p_en),
    .n_period       (p_n),
    .drv_step       (p_step)
  );

  typedef struct {
    logic          dv;
    logic          mode;
    logic [XW-1:0] x;
    logic [XW-1:0] x0;
    logic [XW-1:0] dx1;
    logic [XW-1:0] dx2;
    logic          en;
    logic          dir;
    logic [NW-1:0] nper;
  } vec_t;

  typedef struct {
    int            idx;
    logic          en;
    logic          dir;
    logic [NW-1:0] nper;
  } exp_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];
  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkScoreboard();
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries, expected at least 1");
    end else begin
      e = sb.pop_front();
      checkOutput($sformatf("v%0d_enable", e.idx), int'(drv_enable_sm), int'(e.en));
      checkOutput($sformatf("v%0d_dir", e.idx), int'(drv_dir), int'(e.dir));
      checkOutput($sformatf("v%0d_period", e.idx), int'(n_period), int'(e.nper));
      checkOutput($sformatf("v%0d_step", e.idx), int'(drv_step), 0);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    data_valid     = v.dv;
    tr_mode_enable = v.mode;
    x              = v.x;
    x0             = v.x0;
    dx1            = v.dx1;
    dx2            = v.dx2;
    sb.push_back('{idx, v.en, v.dir, v.nper});
    @(negedge clk);
    data_valid = 1'b0;
    checkScoreboard();
  endtask

  // Holds p_trig high for n clocks from a negedge; reports first step position and step count.
  task automatic pulseRun(input int n, output int first, output int count);
    first = -1;
    count = 0;
    p_trig = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (p_step) begin
        count++;
        if (first < 0) first = i;
      end
    end
    p_trig = 1'b0;
  endtask

  initial begin
    int first;
    int count;
    int last;

    vecs[0]  = '{1'b1, 1'b0, 12'd50,   12'd10,   12'd45,  12'd60, 1'b0, 1'b0, 17'd100000};
    vecs[1]  = '{1'b1, 1'b1, 12'd100,  12'd10,   12'd45,  12'd60, 1'b1, 1'b1, 17'd97120};
    vecs[2]  = '{1'b1, 1'b1, 12'd65,   12'd10,   12'd45,  12'd60, 1'b1, 1'b1, 17'd99360};
    vecs[3]  = '{1'b1, 1'b1, 12'd55,   12'd10,   12'd45,  12'd60, 1'b0, 1'b1, 17'd100000};
    vecs[4]  = '{1'b1, 1'b1, 12'd0,    12'd10,   12'd45,  12'd60, 1'b0, 1'b0, 17'd100000};
    vecs[5]  = '{1'b1, 1'b1, 12'd4095, 12'd10,   12'd45,  12'd60, 1'b1, 1'b1, 17'd1000};
    vecs[6]  = '{1'b1, 1'b1, 12'd10,   12'd10,   12'd45,  12'd60, 1'b0, 1'b1, 17'd100000};
    vecs[7]  = '{1'b1, 1'b1, 12'd71,   12'd10,   12'd45,  12'd60, 1'b1, 1'b1, 17'd98976};
    vecs[8]  = '{1'b1, 1'b1, 12'd56,   12'd10,   12'd45,  12'd60, 1'b1, 1'b1, 17'd99936};
    vecs[9]  = '{1'b1, 1'b0, 12'd4095, 12'd10,   12'd45,  12'd60, 1'b0, 1'b1, 17'd100000};
    vecs[10] = '{1'b1, 1'b1, 12'd1000, 12'd2000, 12'd45,  12'd60, 1'b1, 1'b0, 17'd38880};
    vecs[11] = '{1'b1, 1'b1, 12'd1940, 12'd2000, 12'd45,  12'd60, 1'b1, 1'b0, 17'd99040};
    vecs[12] = '{1'b0, 1'b1, 12'd4095, 12'd10,   12'd45,  12'd60, 1'b1, 1'b0, 17'd99040};
    vecs[13] = '{1'b1, 1'b1, 12'd60,   12'd10,   12'd100, 12'd20, 1'b0, 1'b1, 17'd100000};
    vecs[14] = '{1'b1, 1'b1, 12'd60,   12'd10,   12'd100, 12'd20, 1'b0, 1'b1, 17'd100000};
    vecs[15] = '{1'b1, 1'b1, 12'd0,    12'd4095, 12'd0,   12'd0,  1'b1, 1'b0, 17'd1000};
    vecs[16] = '{1'b0, 1'b0, 12'd0,    12'd10,   12'd45,  12'd60, 1'b0, 1'b0, 17'd100000};

    // Reset must win over active inputs.
    rst = 1'b1;
    tr_mode_enable = 1'b1;
    data_valid = 1'b1;
    data_valid_trig = 1'b1;
    x = 12'd4095;
    repeat (3) @(negedge clk);
    checkOutput("reset_enable", int'(drv_enable_sm), 0);
    checkOutput("reset_dir", int'(drv_dir), 0);
    checkOutput("reset_period", int'(n_period), 100000);
    checkOutput("reset_step", int'(drv_step), 0);
    rst = 1'b0;
    data_valid = 1'b0;
    data_valid_trig = 1'b0;
    tr_mode_enable = 1'b0;
    x = '0;

    $display("[TB] control-path vectors");
    for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i], i);
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("[TB] top-level step timing");
    @(negedge clk);
    tr_mode_enable = 1'b1;
    x0 = 12'd10; dx1 = 12'd45; dx2 = 12'd60;
    x = 12'd4095;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    checkOutput("top_enable_on", int'(drv_enable_sm), 1);
    checkOutput("top_period_min", int'(n_period), 1000);
    data_valid_trig = 1'b1;
    first = -1;
    for (int k = 1; k <= 1100; k++) begin
      @(negedge clk);
      if (drv_step) begin
        first = k;
        break;
      end
    end
    checkOutput("top_first_step_ticks", first, 1000);
    @(negedge clk);
    checkOutput("top_step_one_clock", int'(drv_step), 0);
    count = 0;
    for (int k = 1; k <= 998; k++) begin
      data_valid = (k == 500);
      @(negedge clk);
      if (drv_step) count++;
    end
    data_valid = 1'b0;
    checkOutput("top_no_early_step", count, 0);
    // Counter now sits one tick short of a step; dropping the mode must still suppress it.
    tr_mode_enable = 1'b0;
    @(negedge clk);
    checkOutput("top_mode_drop_enable", int'(drv_enable_sm), 0);
    checkOutput("top_mode_drop_step", int'(drv_step), 0);
    checkOutput("top_mode_drop_period", int'(n_period), 100000);
    count = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (drv_step) count++;
    end
    data_valid_trig = 1'b0;
    checkOutput("top_disabled_no_step", count, 0);

    $display("[TB] standalone pulse generator");
    @(negedge clk);
    p_rst = 1'b0;
    p_en = 1'b1;
    p_n = 17'd4;
    count = 0;
    first = -1;
    last = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (p_step) begin
        count++;
        if (first < 0) first = i;
        last = i;
      end
      p_trig = (i % 5 == 0);
    end
    p_trig = 1'b0;
    checkOutput("pulse_periodic_count", count, 5);
    checkOutput("pulse_periodic_span", last - first, 80);

    pulseRun(2, first, count);
    checkOutput("pulse_premid_steps", count, 0);
    p_rst = 1'b1;
    p_trig = 1'b1;
    @(negedge clk);
    p_rst = 1'b0;
    p_trig = 1'b0;
    checkOutput("pulse_rst_step", int'(p_step), 0);
    pulseRun(10, first, count);
    checkOutput("pulse_after_rst_first", first, 4);
    checkOutput("pulse_after_rst_count", count, 2);

    p_rst = 1'b1;
    @(negedge clk);
    p_rst = 1'b0;
    p_en = 1'b0;
    pulseRun(10, first, count);
    checkOutput("pulse_disabled_count", count, 0);
    p_en = 1'b1;
    pulseRun(4, first, count);
    checkOutput("pulse_reenable_first", first, 4);

    p_n = 17'd0;
    pulseRun(6, first, count);
    checkOutput("pulse_min_period_first", first, 2);
    checkOutput("pulse_min_period_count", count, 3);

    p_n = 17'd8;
    pulseRun(5, first, count);
    checkOutput("pulse_long_no_step", count, 0);
    p_n = 17'd2;
    pulseRun(1, first, count);
    checkOutput("pulse_shrink_fires", first, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
